apb_master_fsm: RTL and testbench

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

---
 rtl/apb_master_fsm.sv | 162 ++++++++++++++++
 tb/tb_apb_master_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// apb_master_fsm
//   AHB-to-APB bridge master sequencer. It accepts one transfer at a time from
//   the AHB side and runs it through the APB SETUP/ACCESS phases. A write is
//   selected when the write FIFO is non-empty at start. The ACCESS phase is
//   aborted after TIMEOUT cycles.
//
// Ports
//   hclk, rst           : clock (rising edge), asynchronous active-high reset
//   i_start_transfer    : one-cycle start pulse (honoured only while idle)
//   i_haddr, i_hsize    : transfer address / size
//   i_fifo_empty        : write FIFO empty (0 at start -> write transfer)
//   i_fifo_wdata        : write FIFO head data
//   o_fifo_rd_en        : one-cycle FIFO pop when a write finishes
//   o_paddr .. o_pstrb  : APB request outputs (all registered)
//   i_prdata, i_pready, i_pslverr : APB completer response
//   o_rdata             : last completed read data (held)
//   o_rdata_valid       : pulse, read data captured this cycle
//   o_done, o_error     : pulse at transfer end, error status alongside
//   o_busy              : a transfer is in SETUP or ACCESS
module apb_master_fsm #(
  parameter int AHB_AW  = 32,
  parameter int AHB_DW  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic              i_start_transfer,
  input  logic [AHB_AW-1:0] i_haddr,
  input  logic [2:0]        i_hsize,
  input  logic              i_fifo_empty,
  input  logic [AHB_DW-1:0] i_fifo_wdata,
  output logic              o_fifo_rd_en,
  output logic [AHB_AW-1:0] o_paddr,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [AHB_DW-1:0] o_pwdata,
  output logic [3:0]        o_pstrb,
  input  logic [AHB_DW-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr,
  output logic [AHB_DW-1:0] o_rdata,
  output logic              o_rdata_valid,
  output logic              o_done,
  output logic              o_error,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Last ACCESS cycle count before the transfer is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_r;
  logic [7:0] cnt_r;
  // Write with an oversized hsize: it runs as a word but reports an error.
  logic       size_err_r;

  // Byte-lane strobes for a transfer; reads drive no strobes.
  function automatic logic [3:0] calc_strb(input logic       write,
                                           input logic [2:0] hsize,
                                           input logic [1:0] addr_lo);
    logic [3:0] strb;
    if (!write) begin
      strb = 4'b0000;
    end else begin
      case (hsize)
        3'd0:    strb = 4'b0001 << addr_lo;
        3'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
        default: strb = 4'b1111;
      endcase
    end
    return strb;
  endfunction

  // Transfer sequencer: state, APB request registers and AHB-side pulses.
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 8'd0;
      size_err_r    <= 1'b0;
      o_paddr       <= '0;
      o_psel        <= 1'b0;
      o_penable     <= 1'b0;
      o_pwrite      <= 1'b0;
      o_pwdata      <= '0;
      o_pstrb       <= 4'b0000;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_fifo_rd_en  <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses unless set below.
      o_rdata_valid <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_fifo_rd_en  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start_transfer) begin
            state_r    <= ST_SETUP;
            o_paddr    <= i_haddr;
            o_pwrite   <= ~i_fifo_empty;
            o_pwdata   <= i_fifo_wdata;
            o_pstrb    <= calc_strb(~i_fifo_empty, i_hsize, i_haddr[1:0]);
            size_err_r <= ~i_fifo_empty & (i_hsize > 3'd2);
            o_psel     <= 1'b1;
            o_penable  <= 1'b0;
            o_busy     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_r   <= ST_ACCESS;
          o_penable <= 1'b1;
          cnt_r     <= 8'd0;
        end
        ST_ACCESS: begin
          if (i_pready) begin
            // Normal completion; pslverr only counts alongside pready.
            state_r      <= ST_IDLE;
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            o_error      <= i_pslverr | size_err_r;
            o_fifo_rd_en <= o_pwrite;
            if (!o_pwrite) begin
              o_rdata       <= i_prdata;
              o_rdata_valid <= 1'b1;
            end
          end else if (cnt_r == CNT_LAST) begin
            // Timeout: abandon the transfer, still consume the write data.
            state_r      <= ST_IDLE;
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            o_error      <= 1'b1;
            o_fifo_rd_en <= o_pwrite;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          o_psel    <= 1'b0;
          o_penable <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm. Transfers are planned per cycle: each plan call
// fills the input table and derives the expected per-cycle outputs from the
// transfer's timing rules. A negedge process compares the DUT to that table,
// and literal pins at chosen cycles check the table itself.
module tb_apb_master_fsm;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int MAXC = 128;
  localparam int NCYC = 102;

  logic          hclk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] haddr;
  logic [2:0]    hsize;
  logic          fifo_empty;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_rd_en;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [DW-1:0] rdata;
  logic          rdata_valid, done, error, busy;

  always #5 hclk = ~hclk;

  apb_master_fsm #(.AHB_AW(AW), .AHB_DW(DW), .TIMEOUT(TO)) dut (
    .hclk(hclk), .rst(rst), .i_start_transfer(start), .i_haddr(haddr),
    .i_hsize(hsize), .i_fifo_empty(fifo_empty), .i_fifo_wdata(fifo_wdata),
    .o_fifo_rd_en(fifo_rd_en), .o_paddr(paddr), .o_psel(psel),
    .o_penable(penable), .o_pwrite(pwrite), .o_pwdata(pwdata),
    .o_pstrb(pstrb), .i_prdata(prdata), .i_pready(pready),
    .i_pslverr(pslverr), .o_rdata(rdata), .o_rdata_valid(rdata_valid),
    .o_done(done), .o_error(error), .o_busy(busy)
  );

  // Per-cycle stimulus
  logic        in_start [MAXC];
  logic [31:0] in_haddr [MAXC];
  logic [2:0]  in_hsize [MAXC];
  logic        in_empty [MAXC];
  logic [31:0] in_wdata [MAXC];
  logic [31:0] in_prdata [MAXC];
  logic        in_pready [MAXC];
  logic        in_pslverr [MAXC];
  // Per-cycle expectations
  logic        exp_psel [MAXC];
  logic        exp_penable [MAXC];
  logic [31:0] exp_paddr [MAXC];
  logic        exp_pwrite [MAXC];
  logic [31:0] exp_pwdata [MAXC];
  logic [3:0]  exp_pstrb [MAXC];
  logic        exp_done [MAXC];
  logic        exp_error [MAXC];
  logic        exp_rvalid [MAXC];
  logic        exp_fifo [MAXC];
  logic [31:0] exp_rdnew [MAXC];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur_cyc = 0;
  bit          chk_en  = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%08h expected=%08h", name, cur_cyc, act, expv);
    end
  endtask

  function automatic logic [3:0] model_strb(input bit wr, input int size, input logic [31:0] addr);
    if (!wr) return 4'd0;
    if (size == 0) return 4'(1 << addr[1:0]);
    if (size == 1) return 4'(3 << (2 * int'(addr[1])));
    return 4'd15;
  endfunction

  // A transfer started in cycle c: SETUP at c+1, ACCESS from c+2 for as many
  // cycles as the slave needs (capped at TO), completion pulses right after.
  task automatic plan(input int c, input logic [31:0] addr, input int size, input bit wr,
                      input logic [31:0] wdata, input int waits, input bit slverr,
                      input logic [31:0] rdv);
    int acc;
    int d;
    bit tmo;
    bit last;
    tmo = (waits >= TO);
    acc = tmo ? TO : waits + 1;
    in_start[c] = 1'b1;
    in_haddr[c] = addr;
    in_hsize[c] = 3'(size);
    in_empty[c] = !wr;
    in_wdata[c] = wdata;
    for (int k = 1; k <= acc + 1; k++) begin
      exp_psel[c+k]    = 1'b1;
      exp_penable[c+k] = (k >= 2);
      exp_paddr[c+k]   = addr;
      exp_pwrite[c+k]  = wr;
      exp_pwdata[c+k]  = wdata;
      exp_pstrb[c+k]   = model_strb(wr, size, addr);
    end
    for (int k = 0; k < acc; k++) begin
      last = !tmo && (k == acc - 1);
      in_pready[c+2+k] = last;
      if (last) begin
        in_pslverr[c+2+k] = slverr;
        in_prdata[c+2+k]  = rdv;
      end
    end
    d = c + 2 + acc;
    exp_done[d]   = 1'b1;
    exp_error[d]  = tmo || slverr || (wr && size > 2);
    exp_rvalid[d] = !wr && !tmo;
    exp_fifo[d]   = wr;
    exp_rdnew[d]  = rdv;
  endtask

  // A start request that the DUT must ignore because it is busy.
  task automatic poke(input int c, input logic [31:0] addr);
    in_start[c] = 1'b1;
    in_haddr[c] = addr;
    in_hsize[c] = 3'd0;
    in_empty[c] = 1'b0;
  endtask

  // Literal pins at selected cycles, written down by hand from the rules.
  task automatic pins(input int c);
    case (c)
      1:  begin chk("pin_setup_psel", 32'(psel), 32'd1); chk("pin_setup_pen", 32'(penable), 32'd0); end
      2:  chk("pin_access_pen", 32'(penable), 32'd1);
      3:  begin
            chk("pin_rd_rdata", rdata, 32'hCAFEF00D);
            chk("pin_rd_valid", 32'(rdata_valid), 32'd1);
            chk("pin_rd_done", 32'(done), 32'd1);
            chk("pin_rd_pop", 32'(fifo_rd_en), 32'd0);
          end
      7:  begin
            chk("pin_bw_pwrite", 32'(pwrite), 32'd1);
            chk("pin_bw_pstrb", 32'(pstrb), 32'h8);
            chk("pin_bw_pwdata", pwdata, 32'h11223344);
            chk("pin_bw_paddr", paddr, 32'h103);
          end
      10: chk("pin_bw_done_early", 32'(done), 32'd0);
      11: begin chk("pin_bw_done", 32'(done), 32'd1); chk("pin_bw_pop", 32'(fifo_rd_en), 32'd1); end
      31: chk("pin_to_last_access", 32'(penable), 32'd1);
      32: begin
            chk("pin_to_psel", 32'(psel), 32'd0);
            chk("pin_to_done", 32'(done), 32'd1);
            chk("pin_to_error", 32'(error), 32'd1);
            chk("pin_to_rvalid", 32'(rdata_valid), 32'd0);
            chk("pin_to_rdata_hold", rdata, 32'hCAFEF00D);
          end
      37: chk("pin_hw_pstrb", 32'(pstrb), 32'hC);
      39: chk("pin_slverr_error", 32'(error), 32'd1);
      40: begin chk("pin_b2b_psel", 32'(psel), 32'd1); chk("pin_b2b_paddr", paddr, 32'h84); end
      42: chk("pin_b2b_rdata", rdata, 32'h12345678);
      43: chk("pin_busy_start_ignored", 32'(psel), 32'd0);
      46: chk("pin_big_pstrb", 32'(pstrb), 32'hF);
      48: chk("pin_big_error", 32'(error), 32'd1);
      52: chk("pin_rd_pstrb", 32'(pstrb), 32'h0);
      78: begin chk("pin_wto_pop", 32'(fifo_rd_en), 32'd1); chk("pin_wto_error", 32'(error), 32'd1); end
      98: begin chk("pin_w15_done", 32'(done), 32'd1); chk("pin_w15_error", 32'(error), 32'd0); end
      default: ;
    endcase
  endtask

  // Compare the DUT against the planned outputs in the middle of every cycle.
  always @(negedge hclk) begin
    if (chk_en) begin
      if (exp_rvalid[cur_cyc]) mdl_rdata = exp_rdnew[cur_cyc];
      chk("psel", 32'(psel), 32'(exp_psel[cur_cyc]));
      chk("penable", 32'(penable), 32'(exp_penable[cur_cyc]));
      chk("busy", 32'(busy), 32'(exp_psel[cur_cyc]));
      chk("done", 32'(done), 32'(exp_done[cur_cyc]));
      chk("error", 32'(error), 32'(exp_error[cur_cyc]));
      chk("rdata_valid", 32'(rdata_valid), 32'(exp_rvalid[cur_cyc]));
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_fifo[cur_cyc]));
      chk("rdata", rdata, mdl_rdata);
      if (exp_psel[cur_cyc]) begin
        chk("paddr", paddr, exp_paddr[cur_cyc]);
        chk("pwrite", 32'(pwrite), 32'(exp_pwrite[cur_cyc]));
        chk("pwdata", pwdata, exp_pwdata[cur_cyc]);
        chk("pstrb", 32'(pstrb), 32'(exp_pstrb[cur_cyc]));
      end
      pins(cur_cyc);
    end
  end

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      in_start[c] = 1'b0;       in_haddr[c] = 32'h0000_0FF0 + 32'(c);
      in_hsize[c] = 3'd2;       in_empty[c] = c[0];
      in_wdata[c] = 32'h5555_0000 | 32'(c);
      in_prdata[c] = 32'hBAD0_0000 | 32'(c);
      in_pready[c] = 1'b0;      in_pslverr[c] = 1'b1;
      exp_psel[c] = 1'b0;       exp_penable[c] = 1'b0;
      exp_paddr[c] = 32'h0;     exp_pwrite[c] = 1'b0;
      exp_pwdata[c] = 32'h0;    exp_pstrb[c] = 4'h0;
      exp_done[c] = 1'b0;       exp_error[c] = 1'b0;
      exp_rvalid[c] = 1'b0;     exp_fifo[c] = 1'b0;
      exp_rdnew[c] = 32'h0;
    end
    plan(0,  32'h40,  2, 1'b0, 32'h0000_0000, 0,  1'b0, 32'hCAFEF00D); // read, zero wait
    plan(6,  32'h103, 0, 1'b1, 32'h11223344,  2,  1'b0, 32'h0);        // byte write, 2 waits
    plan(14, 32'h200, 2, 1'b0, 32'h0,         20, 1'b1, 32'h77777777); // read timeout
    plan(35, 32'h2,   1, 1'b1, 32'hA5A5_5A5A, 1,  1'b1, 32'h0);        // halfword write, slverr
    plan(39, 32'h84,  2, 1'b0, 32'h0,         0,  1'b0, 32'h12345678); // start in done cycle
    poke(41, 32'hFFF0);
    plan(45, 32'h10,  3, 1'b1, 32'h0F0F_0F0F, 0,  1'b0, 32'h0);        // oversized write
    plan(50, 32'h21,  0, 1'b0, 32'h0,         3,  1'b0, 32'hDEADBEEF); // byte read, 3 waits
    poke(51, 32'hEEE0);
    plan(60, 32'h300, 2, 1'b1, 32'h6666_6666, 16, 1'b0, 32'h0);        // write timeout
    plan(80, 32'h304, 2, 1'b1, 32'h7777_0001, 15, 1'b0, 32'h0);        // last cycle before timeout

    rst = 1'b1; start = 1'b0; haddr = '0; hsize = 3'd0; fifo_empty = 1'b1;
    fifo_wdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_paddr", paddr, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      start = in_start[c]; haddr = in_haddr[c]; hsize = in_hsize[c];
      fifo_empty = in_empty[c]; fifo_wdata = in_wdata[c]; prdata = in_prdata[c];
      pready = in_pready[c]; pslverr = in_pslverr[c];
      cur_cyc = c;
      @(posedge hclk);
      #1;
    end
    chk_en = 1'b0;

    // Asynchronous reset in the middle of a write ACCESS phase.
    start = 1'b1; fifo_empty = 1'b0; haddr = 32'h500; hsize = 3'd2;
    fifo_wdata = 32'h0BADCAFE; pready = 1'b0; pslverr = 1'b0;
    @(posedge hclk); #1;
    start = 1'b0;
    @(posedge hclk); #1;
    chk("arst_pre_psel", 32'(psel), 32'd1);
    chk("arst_pre_pen", 32'(penable), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_psel", 32'(psel), 32'd0);
    chk("arst_pen", 32'(penable), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_pop", 32'(fifo_rd_en), 32'd0);
    chk("arst_paddr", paddr, 32'h0);
    chk("arst_pwdata", pwdata, 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    @(posedge hclk); #1;
    rst = 1'b0;
    pready = 1'b1;
    repeat (3) begin
      @(negedge hclk);
      chk("arst_after_done", 32'(done), 32'd0);
      chk("arst_after_pop", 32'(fifo_rd_en), 32'd0);
      chk("arst_after_psel", 32'(psel), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
